// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and helpers for the piano display
// (timing generator and colour stage).
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int   CNT_W        = 10;
    localparam logic SYNC_ACT_DEF = 1'b0;

    typedef logic [CNT_W-1:0] cnt_t;

    // True when lo <= v < hi.
    function automatic logic in_window(input cnt_t v, input int lo, input int hi);
        return (int'(v) >= lo) && (int'(v) < hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: the generator drives it, the colour stage consumes it.
interface vga_timing_gen_if;
    import vga_pkg::*;

    logic hs_vga;
    logic vs_vga;
    logic de;
    cnt_t pix_x;
    cnt_t pix_y;
    logic pix_tick;
    logic frame_start;

    modport master (
        output hs_vga, vs_vga, de, pix_x, pix_y, pix_tick, frame_start
    );

    modport slave (
        input hs_vga, vs_vga, de, pix_x, pix_y, pix_tick, frame_start
    );

endinterface

// File: rtl/vga_timing_gen_clk_en_div.sv
// Clock-enable divider: adv is high on one clk out of every DIV.
// DIV=1 keeps the counter pinned at 0, so adv is permanently high.
module clk_en_div #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic adv
);

    localparam int            W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0]  LAST = W'(DIV - 1);

    logic [W-1:0] div_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (div_cnt == LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + W'(1);
        end
    end

    assign adv = (div_cnt == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: h/v counters advanced by a pixel-rate enable, with
// sync, data-enable and coordinate outputs registered from the next position.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = VGA_H_ACTIVE,
    parameter int   H_FP     = VGA_H_FP,
    parameter int   H_SYNC   = VGA_H_SYNC,
    parameter int   H_BP     = VGA_H_BP,
    parameter int   V_ACTIVE = VGA_V_ACTIVE,
    parameter int   V_FP     = VGA_V_FP,
    parameter int   V_SYNC   = VGA_V_SYNC,
    parameter int   V_BP     = VGA_V_BP,
    parameter int   CLK_DIV  = 2,
    parameter logic SYNC_ACT = SYNC_ACT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    vga_timing_gen_if.master  vga
);

    localparam int   H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int   V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam cnt_t H_LAST  = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST  = cnt_t'(V_TOTAL - 1);

    logic adv;
    cnt_t h_cnt, v_cnt;
    cnt_t h_nxt, v_nxt;
    logic hs_q, vs_q, de_q, tick_q, fs_q;

    clk_en_div #(.DIV(CLK_DIV)) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (adv)
    );

    // Counters reset to the last position so the first advance lands on (0,0).
    always_comb begin
        h_nxt = h_cnt + cnt_t'(1);
        v_nxt = v_cnt;
        if (h_cnt == H_LAST) begin
            h_nxt = '0;
            v_nxt = (v_cnt == V_LAST) ? cnt_t'(0) : v_cnt + cnt_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt  <= H_LAST;
            v_cnt  <= V_LAST;
            hs_q   <= ~SYNC_ACT;
            vs_q   <= ~SYNC_ACT;
            de_q   <= 1'b0;
            tick_q <= 1'b0;
            fs_q   <= 1'b0;
        end else begin
            tick_q <= adv;
            fs_q   <= adv && (h_nxt == '0) && (v_nxt == '0);
            if (adv) begin
                h_cnt <= h_nxt;
                v_cnt <= v_nxt;
                hs_q  <= in_window(h_nxt, H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC)
                         ? SYNC_ACT : ~SYNC_ACT;
                // v_nxt only moves on an h wrap, so vs stays aligned to line starts.
                vs_q  <= in_window(v_nxt, V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC)
                         ? SYNC_ACT : ~SYNC_ACT;
                de_q  <= (int'(h_nxt) < H_ACTIVE) && (int'(v_nxt) < V_ACTIVE);
            end
        end
    end

    assign vga.hs_vga      = hs_q;
    assign vga.vs_vga      = vs_q;
    assign vga.de          = de_q;
    assign vga.pix_x       = h_cnt;
    assign vga.pix_y       = v_cnt;
    assign vga.pix_tick    = tick_q;
    assign vga.frame_start = fs_q;

endmodule
